// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state encoding and the single-cycle ALU evaluation for alu_seq.
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_NOT = 3'd4;
    localparam logic [2:0] OP_MUL = 3'd5;

    // Widest datapath the shared ALU function supports.
    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic             c;
        logic             v;
        logic             ill;
        logic [MAX_W-1:0] y;
    } alu_res_t;

    // Operands arrive zero-extended to MAX_W; only the low w bits take part.
    function automatic alu_res_t alu_eval(input logic [2:0]       op,
                                          input logic [MAX_W-1:0] a,
                                          input logic [MAX_W-1:0] b,
                                          input int unsigned      w);
        alu_res_t         r;
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] top;
        logic [MAX_W-1:0] a_m;
        logic [MAX_W-1:0] b_m;
        logic [MAX_W-1:0] bx;
        logic [MAX_W:0]   full;
        logic [MAX_W:0]   cbit;
        logic             sb;
        logic             sx;
        logic             sy;
        r    = '0;
        full = '0;
        bx   = '0;
        mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
        top  = MAX_W'(1) << (w - 1);
        cbit = (MAX_W + 1)'(1) << w;
        a_m  = a & mask;
        b_m  = b & mask;
        case (op)
            OP_ADD, OP_SUB: begin
                // Subtract is b + ~a + 1 so carry reads as "no borrow".
                bx   = (op == OP_SUB) ? (~a_m & mask) : a_m;
                full = {1'b0, b_m} + {1'b0, bx} + (MAX_W + 1)'(op == OP_SUB);
                r.y  = full[MAX_W-1:0] & mask;
                r.c  = |(full & cbit);
                sb   = |(b_m & top);
                sx   = |(bx & top);
                sy   = |(r.y & top);
                r.v  = (sb == sx) && (sy != sb);
            end
            OP_AND:  r.y = b_m & a_m;
            OP_OR:   r.y = b_m | a_m;
            OP_NOT:  r.y = ~a_m & mask;
            OP_MUL:  r.y = '0;
            default: r.ill = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between operand fetch, alu_seq and register writeback.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic                    in_valid;
    logic                    in_ready;
    logic [2:0]              op;
    logic signed [WIDTH-1:0] a;
    logic signed [WIDTH-1:0] b;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] y;
    logic                    z;
    logic                    n;
    logic                    c;
    logic                    v;
    logic                    illegal;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, y, z, n, c, v, illegal
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, y, z, n, c, v, illegal
    );
endinterface

// File: rtl/alu_mul_iter.sv
// Shift-add multiplier: one partial product per cycle, fixed WIDTH-cycle run.
module alu_mul_iter #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_product
);

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] w_acc_next;

    assign w_acc_next = r_acc + (r_a_sh[0] ? r_b_sh : '0);

    // The final step's sum is offered combinationally so the parent can
    // register it on the same edge that retires the count.
    assign o_done    = (r_cnt == CNT_W'(1));
    assign o_product = w_acc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh <= '0;
            r_b_sh <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
        end else if (i_start) begin
            r_a_sh <= i_a;
            r_b_sh <= i_b;
            r_acc  <= '0;
            r_cnt  <= CNT_W'(WIDTH);
        end else if (r_cnt != '0) begin
            r_acc  <= w_acc_next;
            r_a_sh <= r_a_sh >> 1;
            r_b_sh <= r_b_sh << 1;
            r_cnt  <= r_cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with Z/N/C/V flags and an iterative multiply behind a
// valid/ready handshake on both the request and result side.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_seq_if.slave  bus
);

    if (WIDTH < 4 || WIDTH > MAX_W) begin : g_width_check
        $error("alu_seq: WIDTH out of supported range");
    end

    state_t                  r_state;
    state_t                  w_next;
    logic                    w_in_ready;
    logic                    w_accept;
    logic                    w_mul_start;
    logic                    w_mul_done;
    logic [WIDTH-1:0]        w_product;
    alu_res_t                w_res;
    logic [WIDTH-1:0]        w_alu_y;
    logic                    w_unused;
    logic signed [WIDTH-1:0] r_y;
    logic                    r_z;
    logic                    r_n;
    logic                    r_c;
    logic                    r_v;
    logic                    r_ill;

    assign w_res    = alu_eval(bus.op, MAX_W'($unsigned(bus.a)),
                               MAX_W'($unsigned(bus.b)), WIDTH);
    assign w_alu_y  = w_res.y[WIDTH-1:0];
    assign w_unused = ^(w_res.y >> WIDTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_accept    = 1'b0;
        w_mul_start = 1'b0;
        case (r_state)
            ST_IDLE: w_in_ready = 1'b1;
            ST_DONE: w_in_ready = bus.out_ready;
            default: w_in_ready = 1'b0;
        endcase
        w_accept    = bus.in_valid && w_in_ready;
        w_mul_start = w_accept && (bus.op == OP_MUL);
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_next = w_mul_start ? ST_BUSY : ST_DONE;
            end
            ST_BUSY: begin
                if (w_mul_done) w_next = ST_DONE;
            end
            ST_DONE: begin
                if (w_accept)           w_next = w_mul_start ? ST_BUSY : ST_DONE;
                else if (bus.out_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_mul_start),
        .i_a      (bus.a),
        .i_b      (bus.b),
        .o_done   (w_mul_done),
        .o_product(w_product)
    );

    // Result and flags only move on an accepted ALU op or a finishing multiply,
    // so they stay frozen while DONE waits on the consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y   <= '0;
            r_z   <= 1'b0;
            r_n   <= 1'b0;
            r_c   <= 1'b0;
            r_v   <= 1'b0;
            r_ill <= 1'b0;
        end else if (w_accept && !w_mul_start) begin
            r_y   <= w_alu_y;
            r_z   <= (w_alu_y == '0);
            r_n   <= w_alu_y[WIDTH-1];
            r_c   <= w_res.c;
            r_v   <= w_res.v;
            r_ill <= w_res.ill;
        end else if (r_state == ST_BUSY && w_mul_done) begin
            r_y   <= w_product;
            r_z   <= (w_product == '0);
            r_n   <= w_product[WIDTH-1];
            r_c   <= 1'b0;
            r_v   <= 1'b0;
            r_ill <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.y         = r_y;
    assign bus.z         = r_z;
    assign bus.n         = r_n;
    assign bus.c         = r_c;
    assign bus.v         = r_v;
    assign bus.illegal   = r_ill;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at WIDTH=32 and WIDTH=8: directed cases plus random ops
// compared against an arithmetic reference model.
module tb_alu_seq;

    localparam int W0 = 32;
    localparam int W1 = 8;

    typedef struct packed {
        logic [31:0] y;
        logic        z;
        logic        n;
        logic        c;
        logic        v;
        logic        ill;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    res_t last;

    alu_seq_if #(.WIDTH(W0)) bus0 ();
    alu_seq_if #(.WIDTH(W1)) bus1 ();

    alu_seq #(.WIDTH(W0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    alu_seq #(.WIDTH(W1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic res_t model(input int w, input logic [2:0] op,
                                   input logic [31:0] a, input logic [31:0] b);
        longint unsigned m, ua, ub, r;
        longint          sa, sb, sr, hi, lo;
        res_t            e;
        m  = (64'd1 << w) - 64'd1;
        ua = longint'(a) & m;
        ub = longint'(b) & m;
        sa = ((ua >> (w - 1)) != 0) ? longint'(ua) - longint'(m) - 1 : longint'(ua);
        sb = ((ub >> (w - 1)) != 0) ? longint'(ub) - longint'(m) - 1 : longint'(ub);
        hi = (64'sd1 <<< (w - 1)) - 1;
        lo = -hi - 1;
        e  = '0;
        r  = 0;
        case (op)
            3'd0: begin
                r = ub + ua; sr = sb + sa;
                e.c = (r > m); e.v = (sr > hi) || (sr < lo);
            end
            3'd1: begin
                r = (ub - ua) & m; sr = sb - sa;
                e.c = (ub >= ua); e.v = (sr > hi) || (sr < lo);
            end
            3'd2:    r = ub & ua;
            3'd3:    r = ub | ua;
            3'd4:    r = ~ua;
            3'd5:    r = ua * ub;
            default: e.ill = 1'b1;
        endcase
        e.y = 32'(r & m);
        e.z = (e.y == 32'd0);
        e.n = e.y[w-1];
        return e;
    endfunction

    function automatic res_t rd_res(input bit s);
        if (s) return {24'h0, bus1.y, bus1.z, bus1.n, bus1.c, bus1.v, bus1.illegal};
        return {bus0.y, bus0.z, bus0.n, bus0.c, bus0.v, bus0.illegal};
    endfunction

    function automatic logic rd_ov(input bit s);
        return s ? bus1.out_valid : bus0.out_valid;
    endfunction

    function automatic logic rd_ir(input bit s);
        return s ? bus1.in_ready : bus0.in_ready;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'h7FFFFFFF;
            3:       return 32'h80000000;
            4:       return 32'hFFFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit s, input logic vld, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        if (s) begin
            bus1.in_valid = vld; bus1.op = op; bus1.a = a[7:0]; bus1.b = b[7:0];
        end else begin
            bus0.in_valid = vld; bus0.op = op; bus0.a = a; bus0.b = b;
        end
    endtask

    task automatic set_ordy(input bit s, input logic r);
        if (s) bus1.out_ready = r;
        else   bus0.out_ready = r;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input bit s, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit consume, input string tag);
        int   w;
        int   lat;
        int   guard;
        bit   leak;
        res_t exp;
        w   = s ? W1 : W0;
        exp = model(w, op, a, b);
        guard = 0;
        while (!rd_ir(s) && guard < 100) begin
            step();
            guard++;
        end
        chk({tag, "/in_ready"}, 64'(rd_ir(s)), 64'd1);
        drive(s, 1'b1, op, a, b);
        step();
        // Scramble operands after acceptance; the op in flight must not see them.
        drive(s, 1'b0, 3'($urandom), $urandom, $urandom);
        lat  = 1;
        leak = 1'b0;
        while (!rd_ov(s) && lat < 200) begin
            if (rd_ir(s)) leak = 1'b1;
            drive(s, 1'b1, 3'($urandom), $urandom, $urandom);
            step();
            lat++;
        end
        drive(s, 1'b0, 3'd0, 32'h0, 32'h0);
        chk({tag, "/latency"}, 64'(lat), 64'((op == 3'd5) ? w + 1 : 1));
        chk({tag, "/busy_ready"}, 64'(leak), 64'd0);
        last = rd_res(s);
        chk({tag, "/result"}, 64'(last), 64'(exp));
        if (consume) begin
            set_ordy(s, 1'b1);
            step();
            set_ordy(s, 1'b0);
            chk({tag, "/consumed"}, 64'(rd_ov(s)), 64'd0);
        end
    endtask

    initial begin
        res_t snap;
        bit   stale;
        drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 3'd0, 32'h0, 32'h0);
        set_ordy(1'b0, 1'b0);
        set_ordy(1'b1, 1'b0);
        repeat (2) step();
        chk("reset/result", 64'(rd_res(1'b0)), 64'd0);
        chk("reset/out_valid", 64'(rd_ov(1'b0)), 64'd0);
        chk("reset/in_ready", 64'(rd_ir(1'b0)), 64'd1);
        rst_n = 1'b1;
        step();

        run_op(1'b0, 3'd0, 32'd5, 32'd7, 1'b1, "add_5_7");
        chk("add_5_7/lit", 64'(last), 64'({32'd12, 5'b00000}));
        run_op(1'b0, 3'd1, 32'd7, 32'd5, 1'b1, "sub_7_5");
        chk("sub_7_5/lit", 64'(last), 64'({32'hFFFFFFFE, 5'b01000}));
        run_op(1'b0, 3'd0, 32'd1, 32'h7FFFFFFF, 1'b1, "add_ovf");
        chk("add_ovf/lit", 64'(last), 64'({32'h80000000, 5'b01010}));
        run_op(1'b0, 3'd0, 32'd1, 32'hFFFFFFFF, 1'b1, "add_carry");
        chk("add_carry/lit", 64'(last), 64'({32'h0, 5'b10100}));
        run_op(1'b0, 3'd5, 32'hFFFFFFFD, 32'd7, 1'b1, "mul_m3_7");
        chk("mul_m3_7/lit", 64'(last), 64'({32'hFFFFFFEB, 5'b01000}));

        // Backpressure, then a same-edge consume/accept.
        run_op(1'b0, 3'd2, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, "and_bp");
        chk("and_bp/lit", 64'(last), 64'({32'hF000F000, 5'b01000}));
        snap = rd_res(1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 3'd0, 32'h55, 32'h66);
            step();
            chk("bp_hold", 64'({rd_res(1'b0), rd_ov(1'b0), rd_ir(1'b0)}),
                64'({snap, 1'b1, 1'b0}));
        end
        drive(1'b0, 1'b1, 3'd3, 32'd1, 32'd2);
        set_ordy(1'b0, 1'b1);
        step();
        drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        set_ordy(1'b0, 1'b0);
        chk("b2b/out_valid", 64'(rd_ov(1'b0)), 64'd1);
        chk("b2b/result", 64'(rd_res(1'b0)), 64'({32'd3, 5'b00000}));
        set_ordy(1'b0, 1'b1);
        step();
        set_ordy(1'b0, 1'b0);

        run_op(1'b0, 3'd6, 32'd9, 32'd9, 1'b1, "illegal");
        chk("illegal/lit", 64'(last), 64'({32'h0, 5'b10001}));
        run_op(1'b0, 3'd4, 32'd0, 32'd0, 1'b1, "not_0");
        chk("not_0/lit", 64'(last), 64'({32'hFFFFFFFF, 5'b01000}));

        // Asynchronous reset in the middle of a multiply.
        drive(1'b0, 1'b1, 3'd5, 32'hFFFFFFFD, 32'd7);
        step();
        drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        repeat (10) step();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst/result", 64'(rd_res(1'b0)), 64'd0);
        chk("mid_rst/out_valid", 64'(rd_ov(1'b0)), 64'd0);
        chk("mid_rst/in_ready", 64'(rd_ir(1'b0)), 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (rd_ov(1'b0)) stale = 1'b1;
        end
        chk("mid_rst/no_stale", 64'(stale), 64'd0);

        run_op(1'b1, 3'd0, 32'd5, 32'd7, 1'b1, "w8_add");
        chk("w8_add/lit", 64'(last), 64'({32'd12, 5'b00000}));
        run_op(1'b1, 3'd5, 32'h10, 32'h10, 1'b1, "w8_mul_zero");
        chk("w8_mul_zero/lit", 64'(last), 64'({32'h0, 5'b10000}));
        run_op(1'b1, 3'd5, 32'hFD, 32'd7, 1'b1, "w8_mul_m3_7");
        chk("w8_mul_m3_7/lit", 64'(last), 64'({32'hEB, 5'b01000}));

        for (int i = 0; i < 30; i++)
            run_op(1'b0, 3'($urandom_range(0, 7)), pick(), pick(), 1'b1, "rnd32");
        for (int i = 0; i < 20; i++)
            run_op(1'b1, 3'($urandom_range(0, 7)), pick(), pick(), 1'b1, "rnd8");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Registered, parametrised-width successor to the team's combinational integer ALU.
- Accepts one operation per valid/ready handshake and returns the result with four status flags Z/N/C/V.
- Adds an iterative shift-add multiply that runs for WIDTH cycles.
- Sits between operand fetch and register writeback in the fp_180b datapath.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4).
- CNT_W, $clog2(WIDTH+1), multiply step-counter width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept an operation this cycle.
- op  in  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOT, 5 MUL, 6/7 illegal.
- a  in  WIDTH  operand A, signed.
- b  in  WIDTH  operand B, signed.
- out_valid  out  1  result register holds a valid result.
- out_ready  in  1  consumer takes the result.
- y  out  WIDTH  result, signed.
- z, n, c, v  out  1 each  zero, negative, carry, overflow flags.
- illegal  out  1  result came from an illegal opcode.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; y=0; z=n=c=v=illegal=0; out_valid=0; multiply counter and accumulator cleared. A reset mid-multiply aborts the multiply with no output.
- Operand order is fixed:
  - ADD: y=b+a
  - SUB: y=b-a
  - AND: y=b&a
  - OR: y=b|a
  - NOT: y=~a
  - MUL: y=low WIDTH bits of b*a (the same bits for signed or unsigned)
  - Illegal: y=0, illegal=1
- Flags are registered together with y:
  - z = (y==0)
  - n = y[WIDTH-1]
  - ADD: c = carry out of b+a; v = signed overflow
  - SUB: computed as b+~a+1; c = carry out (1 = no borrow); v = signed overflow
  - AND/OR/NOT/MUL/illegal: c=v=0
- States:
  - IDLE: in_ready=1, out_valid=0.
  - BUSY: multiply in progress; in_ready=0, out_valid=0.
  - DONE: out_valid=1; y and flags held stable until out_ready=1.
- Acceptance occurs on a clk edge where in_valid && in_ready.
- ALU ops (0-4, 6, 7): result registered on the acceptance edge, then ->DONE. out_valid is high in the cycle after acceptance (latency 1).
- MUL:
  - Acceptance edge loads a_sh=a, b_sh=b, acc=0, cnt=WIDTH, then ->BUSY.
  - Each BUSY edge: acc += a_sh[0] ? b_sh : 0; a_sh>>=1 (logical); b_sh<<=1; cnt-=1.
  - The edge that takes cnt to 0 writes acc to y, sets flags, ->DONE.
  - out_valid is therefore high WIDTH cycles after the ALU-op point (latency WIDTH+1). There is no early termination, so latency is fixed.
- DONE with out_ready=1:
  - Result is consumed on that edge.
  - in_ready = (state==IDLE) || (state==DONE && out_ready). This allows back-to-back accept in the same cycle.
  - If in_valid=1 also, the new op is accepted on that same edge and the next state follows the rules above (DONE for ALU ops, BUSY for MUL).
  - Otherwise ->IDLE.
- DONE with out_ready=0: hold everything; in_ready=0; inputs are ignored.
- Inputs a, b, op are sampled only on the acceptance edge. Later changes do not affect an op in flight.
- in_valid while BUSY: not accepted. The requester must hold the request.
- Wrap-around: ADD/SUB/MUL results wrap modulo 2^WIDTH. Wrap is signalled only through c and v as defined above.

Decomposition:
- Package alu_seq_pkg:
  - Opcode localparams OP_ADD..OP_MUL.
  - State encoding IDLE/BUSY/DONE.
  - Function returning {c,v,y} for the single-cycle ops.
- Sub-module alu_mul_iter:
  - Owns a_sh, b_sh, acc, cnt.
  - Inputs: start, a, b. Outputs: done (one-cycle pulse), product.
  - The parent FSM holds the handshake and the result/flag registers.

Test Plan:
- ADD a=5, b=7 -> y=12, z=n=c=v=0, out_valid 1 cycle after accept. SUB a=7, b=5 -> y=0xFFFFFFFE, n=1, c=0, v=0.
- ADD a=1, b=0x7FFFFFFF -> y=0x80000000, n=1, v=1, c=0. ADD a=1, b=0xFFFFFFFF -> y=0, z=1, c=1, v=0.
- MUL a=-3 (0xFFFFFFFD), b=7 -> y=0xFFFFFFEB, n=1, out_valid exactly 32 cycles after the ALU-op point; in_ready=0 and extra in_valid ignored throughout BUSY.
- Backpressure: AND a=0xF0F0F0F0, b=0xFF00FF00 -> y=0xF000F000; hold out_ready=0 for 5 cycles -> y/flags/out_valid stable, in_ready=0; then out_ready=1 with in_valid=1, OR a=1, b=2 -> accepted the same edge, next y=3.
- op=6, a=9, b=9 -> y=0, z=1, illegal=1, c=v=0. Next op NOT a=0 -> y=0xFFFFFFFF, n=1, illegal=0.
- Reset: rst_n=0 asserted asynchronously 10 cycles into a MUL -> outputs 0 immediately, state IDLE, no stale result after release. Repeat the MUL/ADD directed cases with WIDTH=8 (MUL 0x10*0x10 -> 0x00, z=1).
